// File: rtl/button_conditioner_if.sv
// Signal bundle between the raw pushbutton pins and the conditioned outputs of button_conditioner.
// There is no valid/ready handshake: btn_raw is sampled on every clock, and every output is a registered level or a single-cycle pulse.
interface button_conditioner_if;
    logic [4:0] btn_raw;
    logic [4:0] btn_level;
    logic [4:0] btn_pulse;
    logic       long_c;
    logic [9:0] dbg_state;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_pulse,
        input  long_c,
        input  dbg_state
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_pulse,
        output long_c,
        output dbg_state
    );
endinterface

// File: rtl/button_conditioner.sv
// Five-button input stage: 2-flop synchroniser, per-button debounce FSM, auto-repeat on the
// navigation keys and a one-shot long-press pulse on C.
module button_conditioner #(
    parameter int         DEBOUNCE_CYCLES = 125000,
    parameter int         REPEAT_DELAY    = 3125000,
    parameter int         REPEAT_PERIOD   = 937500,
    parameter logic [4:0] REPEAT_MASK     = 5'b11110,
    parameter int         LONG_CYCLES     = 12500000
) (
    input logic                clk,
    input logic                reset_n,
    button_conditioner_if.slave bus
);

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAXP = max_of(max_of(DEBOUNCE_CYCLES, REPEAT_DELAY),
                                 max_of(REPEAT_PERIOD, LONG_CYCLES));
    localparam int CW = $clog2(MAXP) + 1;

    localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] RPT_LAST   = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RPT_RELOAD = CW'(REPEAT_DELAY - REPEAT_PERIOD);
    localparam logic [CW-1:0] LONG_LAST  = CW'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CONF_PRESS = 2'd1,
        HELD       = 2'd2,
        CONF_REL   = 2'd3
    } state_t;

    state_t        state_q [5];
    logic [CW-1:0] deb_q   [5];
    logic [CW-1:0] rpt_q   [5];
    logic [CW-1:0] hold_q  [5];
    logic [4:0]    sync1_q;
    logic [4:0]    sync2_q;
    logic [4:0]    level_q;
    logic [4:0]    pulse_q;
    logic          long_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            pulse_q <= '0;
            long_q  <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                state_q[i] <= IDLE;
                deb_q[i]   <= '0;
                rpt_q[i]   <= '0;
                hold_q[i]  <= '0;
            end
        end else begin
            sync1_q <= bus.btn_raw;
            sync2_q <= sync1_q;
            pulse_q <= '0;
            long_q  <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                case (state_q[i])
                    IDLE: begin
                        if (sync2_q[i]) begin
                            state_q[i] <= CONF_PRESS;
                            deb_q[i]   <= '0;
                        end
                    end
                    CONF_PRESS: begin
                        if (!sync2_q[i]) begin
                            state_q[i] <= IDLE;
                        end else if (deb_q[i] == DEB_LAST) begin
                            state_q[i] <= HELD;
                            level_q[i] <= 1'b1;
                            pulse_q[i] <= 1'b1;
                            rpt_q[i]   <= '0;
                            hold_q[i]  <= '0;
                        end else begin
                            deb_q[i] <= deb_q[i] + 1'b1;
                        end
                    end
                    HELD: begin
                        if (!sync2_q[i]) begin
                            state_q[i] <= CONF_REL;
                            deb_q[i]   <= '0;
                        end else begin
                            // hold_q saturates so the long-press compare can never match twice
                            if (hold_q[i] != '1) hold_q[i] <= hold_q[i] + 1'b1;
                            if (i == 0 && hold_q[i] == LONG_LAST) long_q <= 1'b1;
                            if (REPEAT_MASK[i] && rpt_q[i] == RPT_LAST) begin
                                pulse_q[i] <= 1'b1;
                                rpt_q[i]   <= RPT_RELOAD;
                            end else if (rpt_q[i] != '1) begin
                                rpt_q[i] <= rpt_q[i] + 1'b1;
                            end
                        end
                    end
                    CONF_REL: begin
                        if (sync2_q[i]) begin
                            state_q[i] <= HELD;
                        end else if (deb_q[i] == DEB_LAST) begin
                            state_q[i] <= IDLE;
                            level_q[i] <= 1'b0;
                        end else begin
                            deb_q[i] <= deb_q[i] + 1'b1;
                        end
                    end
                    default: state_q[i] <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        bus.dbg_state = '0;
        for (int i = 0; i < 5; i++) bus.dbg_state[2*i +: 2] = state_q[i];
    end

    assign bus.btn_level = level_q;
    assign bus.btn_pulse = pulse_q;
    assign bus.long_c    = long_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: an edge-level behavioural model feeding an expected
// queue, checked every cycle, plus hand-computed literal checks per scenario.
module tb_button_conditioner;

    localparam int DEB  = 4;
    localparam int RD   = 10;
    localparam int RP   = 3;
    localparam int LONG = 20;
    localparam logic [4:0] MASK = 5'b11110;

    logic clk;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    button_conditioner_if bus ();

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .REPEAT_MASK    (MASK),
        .LONG_CYCLES    (LONG)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model and scoreboard ----------------
    // An edge sees the raw level sampled two edges earlier. A level change is accepted once the
    // seen value has disagreed with the level for DEB+1 consecutive edges. Held edges are counted
    // only while the button is seen high on two consecutive edges after acceptance.
    logic [10:0] exp_q[$];
    logic [4:0]  raw_hist[$];
    int          run [5];
    int          n_held [5];
    bit          m_lvl [5];
    bit          m_prev [5];

    task automatic model_clear();
        exp_q.delete();
        raw_hist.delete();
        for (int i = 0; i < 5; i++) begin
            run[i] = 0; n_held[i] = 0; m_lvl[i] = 0; m_prev[i] = 0;
        end
    endtask

    initial model_clear();

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            model_clear();
        end else begin
            logic [4:0] seen;
            logic [4:0] e_lvl;
            logic [4:0] e_pls;
            logic       e_long;
            seen   = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size()-2] : 5'b0;
            e_pls  = '0;
            e_long = 1'b0;
            raw_hist.push_back(bus.btn_raw);
            if (raw_hist.size() > 2) void'(raw_hist.pop_front());
            for (int i = 0; i < 5; i++) begin
                bit s;
                s = seen[i];
                if (s != m_lvl[i]) run[i]++; else run[i] = 0;
                if (run[i] == DEB + 1) begin
                    m_lvl[i] = s;
                    run[i]   = 0;
                    if (s) begin
                        e_pls[i]  = 1'b1;
                        n_held[i] = 0;
                    end
                end else if (m_lvl[i] && s && m_prev[i]) begin
                    n_held[i]++;
                    if (MASK[i] && n_held[i] >= RD && ((n_held[i] - RD) % RP) == 0) e_pls[i] = 1'b1;
                    if (i == 0 && n_held[i] == LONG) e_long = 1'b1;
                end
                m_prev[i] = s;
                e_lvl[i]  = m_lvl[i];
            end
            exp_q.push_back({e_lvl, e_pls, e_long});
        end
    end

    always @(negedge clk) begin
        logic [10:0] act;
        logic [10:0] e;
        act = {bus.btn_level, bus.btn_pulse, bus.long_c};
        if (!reset_n) begin
            checks++;
            if (act !== 11'b0) begin
                errors++;
                $display("FAIL reset_outputs: got %b expected %b at %0t", act, 11'b0, $time);
            end
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL model_cmp: got lvl=%b pls=%b long=%b expected lvl=%b pls=%b long=%b at %0t",
                         act[10:6], act[5:1], act[0], e[10:6], e[5:1], e[0], $time);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic drive(input logic [4:0] v);
        @(negedge clk);
        bus.btn_raw = v;
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int cnt;
        int cnt_long;
        int rep_edges[7];
        bit hit;
        rep_edges = '{6, 16, 19, 22, 25, 28, 31};

        reset_n     = 1'b0;
        bus.btn_raw = 5'b0;
        wait_n(3);
        check("reset_level", {27'b0, bus.btn_level}, 32'h0);
        check("reset_pulse", {27'b0, bus.btn_pulse}, 32'h0);
        check("reset_long",  {31'b0, bus.long_c},    32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_n(3);

        // 1: clean press of U, held for 8 edges
        drive(5'b00010);
        wait_n(6);
        check("t1_no_early_pulse", {27'b0, bus.btn_pulse}, 32'h0);
        wait_n(1);
        check("t1_pulse", {27'b0, bus.btn_pulse}, 32'h02);
        check("t1_level", {27'b0, bus.btn_level}, 32'h02);
        wait_n(1);
        check("t1_pulse_one_cycle", {27'b0, bus.btn_pulse}, 32'h0);
        bus.btn_raw = 5'b0;
        wait_n(6);
        check("t1_level_still_high", {31'b0, bus.btn_level[1]}, 32'h1);
        wait_n(1);
        check("t1_level_fall", {31'b0, bus.btn_level[1]}, 32'h0);
        wait_n(8);

        // 2: bounce on U, last rise on edge 4 -> pulse on edge 10
        drive(5'b00010);
        cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.btn_pulse[1]) cnt++;
            if (k == 11) check("t2_pulse_edge10", {31'b0, bus.btn_pulse[1]}, 32'h1);
            if (k == 1 || k == 3) bus.btn_raw = 5'b0;
            if (k == 2 || k == 4) bus.btn_raw = 5'b00010;
            if (k == 20) bus.btn_raw = 5'b0;
        end
        check("t2_single_pulse", cnt, 32'd1);
        wait_n(10);

        // 3: D held 30 edges -> press at 6, repeats 16,19,22,...
        drive(5'b00100);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            hit = 1'b0;
            foreach (rep_edges[j]) if (rep_edges[j] == k - 1) hit = 1'b1;
            check($sformatf("t3_pulse_edge%0d", k - 1), {31'b0, bus.btn_pulse[2]}, {31'b0, hit});
            if (k == 36) check("t3_level_held", {31'b0, bus.btn_level[2]}, 32'h1);
            if (k == 37) check("t3_level_fall", {31'b0, bus.btn_level[2]}, 32'h0);
            if (k == 30) bus.btn_raw = 5'b0;
        end
        wait_n(6);

        // 4: C held 40 edges -> one press pulse, long_c at edge 26 only
        drive(5'b00001);
        cnt = 0;
        cnt_long = 0;
        for (int k = 1; k <= 55; k++) begin
            @(negedge clk);
            if (bus.btn_pulse[0]) cnt++;
            if (bus.long_c) cnt_long++;
            if (k == 26 || k == 28) check("t4_long_neighbour", {31'b0, bus.long_c}, 32'h0);
            if (k == 27) check("t4_long_edge26", {31'b0, bus.long_c}, 32'h1);
            if (k == 40) bus.btn_raw = 5'b0;
        end
        check("t4_c_pulses", cnt, 32'd1);
        check("t4_long_pulses", cnt_long, 32'd1);
        check("t4_level_released", {31'b0, bus.btn_level[0]}, 32'h0);

        // 5: U and L together, then a one-cycle glitch on R
        drive(5'b01010);
        wait_n(7);
        check("t5_joint_pulse", {27'b0, bus.btn_pulse}, 32'h0A);
        wait_n(3);
        bus.btn_raw = 5'b0;
        wait_n(10);
        drive(5'b10000);
        cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) bus.btn_raw = 5'b0;
            if (bus.btn_pulse[4] || bus.btn_level[4]) cnt++;
        end
        check("t5_glitch_rejected", cnt, 32'd0);

        // 6: reset while R held, then re-debounce with R still high
        drive(5'b10000);
        wait_n(10);
        check("t6_level_before_reset", {27'b0, bus.btn_level}, 32'h10);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_async_level", {27'b0, bus.btn_level}, 32'h0);
        check("t6_async_pulse", {27'b0, bus.btn_pulse}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_n(6);
        check("t6_no_early_pulse", {27'b0, bus.btn_pulse}, 32'h0);
        wait_n(1);
        check("t6_repulse", {27'b0, bus.btn_pulse}, 32'h10);
        check("t6_relevel", {27'b0, bus.btn_level}, 32'h10);
        bus.btn_raw = 5'b0;
        wait_n(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
